// File: rtl/lbp_window_agu.sv
// Window address generator for the LBP datapath: scans the window centre over the image and issues gray fetches per fill.
// Define LBP_AGU_SNAKE_EN for serpentine scan; the default build does a raster scan with an init fill per row.
module lbp_window_agu #(
  parameter int ADDR_W = 7,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int WIN    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                gray_req,
  input  logic                gray_ready,
  output logic [2*ADDR_W-1:0] gray_addr,
  output logic [1:0]          fill_dir,
  output logic [5:0]          fill_idx,
  output logic [2*ADDR_W-1:0] lbp_addr,
  output logic                lbp_valid,
  input  logic                proc_ready,
  output logic                busy,
  output logic                done
);

  // state | meaning: IDLE wait start | FETCH issue fill | WAIT hold window | FINISH done pulse
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_FINISH} state_t;

  localparam int R = (WIN - 1) / 2;
  localparam logic [ADDR_W-1:0] C_R    = ADDR_W'(R);
  localparam logic [ADDR_W-1:0] C_XMAX = ADDR_W'(IMG_W - 1 - R);
  localparam logic [ADDR_W-1:0] C_YMAX = ADDR_W'(IMG_H - 1 - R);
  localparam logic [5:0] LAST_INIT = 6'(WIN * WIN - 1);
  localparam logic [5:0] LAST_EDGE = 6'(WIN - 1);
  localparam logic [2:0] LAST_OFF  = 3'(WIN - 1);
  localparam logic [1:0] DIR_INIT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  state_t              r_state, w_state;
  logic [ADDR_W-1:0]   r_row, w_row, r_col, w_col;
  logic [1:0]          r_dir, w_dir;
  logic [5:0]          r_idx, w_idx;
  logic [2:0]          r_oa, w_oa, r_ob, w_ob;
  logic                r_req, w_req, r_valid, w_valid, r_busy, w_busy, r_done, w_done;
  logic [2*ADDR_W-1:0] r_gaddr;
  logic [ADDR_W-1:0]   w_grow, w_gcol;
  logic [5:0]          w_last_idx;
  logic                w_last_win;
`ifdef LBP_AGU_SNAKE_EN
  logic                r_left, w_left;
`endif

  always_comb begin
    w_state = r_state;
    w_row   = r_row;
    w_col   = r_col;
    w_dir   = r_dir;
    w_idx   = r_idx;
    w_oa    = r_oa;
    w_ob    = r_ob;
    w_req   = r_req;
    w_valid = r_valid;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_last_idx = (r_dir == DIR_INIT) ? LAST_INIT : LAST_EDGE;
`ifdef LBP_AGU_SNAKE_EN
    w_left     = r_left;
    w_last_win = (r_row == C_YMAX) && (r_col == (r_left ? C_R : C_XMAX));
`else
    w_last_win = (r_row == C_YMAX) && (r_col == C_XMAX);
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_row   = C_R;
          w_col   = C_R;
          w_dir   = DIR_INIT;
          w_idx   = '0;
          w_oa    = '0;
          w_ob    = '0;
          w_busy  = 1'b1;
          w_req   = 1'b1;
          w_state = S_FETCH;
`ifdef LBP_AGU_SNAKE_EN
          w_left  = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        if (gray_ready) begin
          if (r_idx == w_last_idx) begin
            w_req   = 1'b0;
            w_valid = 1'b1;
            w_state = S_WAIT;
          end else begin
            w_idx = r_idx + 6'd1;
            // a: row offset within the fill, b: column offset
            case (r_dir)
              DIR_INIT: begin
                if (r_ob == LAST_OFF) begin
                  w_ob = '0;
                  w_oa = r_oa + 3'd1;
                end else begin
                  w_ob = r_ob + 3'd1;
                end
              end
              DIR_DOWN: w_ob = r_ob + 3'd1;
              default:  w_oa = r_oa + 3'd1;
            endcase
          end
        end
      end
      S_WAIT: begin
        if (proc_ready) begin
          w_valid = 1'b0;
          if (w_last_win) begin
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_state = S_FINISH;
          end else begin
            w_idx   = '0;
            w_oa    = '0;
            w_ob    = '0;
            w_req   = 1'b1;
            w_state = S_FETCH;
`ifdef LBP_AGU_SNAKE_EN
            if (!r_left && r_col != C_XMAX) begin
              w_col = r_col + 1'b1;
              w_dir = DIR_RIGHT;
            end else if (r_left && r_col != C_R) begin
              w_col = r_col - 1'b1;
              w_dir = DIR_LEFT;
            end else begin
              w_row  = r_row + 1'b1;
              w_dir  = DIR_DOWN;
              w_left = !r_left;
            end
`else
            if (r_col != C_XMAX) begin
              w_col = r_col + 1'b1;
              w_dir = DIR_RIGHT;
            end else begin
              w_row = r_row + 1'b1;
              w_col = C_R;
              w_dir = DIR_INIT;
            end
`endif
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
    // fetch address derived from next-cycle state so gray_addr can be a plain register
    w_grow = (w_dir == DIR_DOWN) ? w_row + C_R : w_row - C_R + ADDR_W'(w_oa);
    case (w_dir)
      DIR_RIGHT: w_gcol = w_col + C_R;
      DIR_LEFT:  w_gcol = w_col - C_R;
      default:   w_gcol = w_col - C_R + ADDR_W'(w_ob);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_dir   <= '0;
      r_idx   <= '0;
      r_oa    <= '0;
      r_ob    <= '0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gaddr <= '0;
`ifdef LBP_AGU_SNAKE_EN
      r_left  <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_row   <= w_row;
      r_col   <= w_col;
      r_dir   <= w_dir;
      r_idx   <= w_idx;
      r_oa    <= w_oa;
      r_ob    <= w_ob;
      r_req   <= w_req;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_done  <= w_done;
      if (w_req) r_gaddr <= {w_grow, w_gcol};
`ifdef LBP_AGU_SNAKE_EN
      r_left  <= w_left;
`endif
    end
  end

  assign gray_req  = r_req;
  assign gray_addr = r_gaddr;
  assign fill_dir  = r_dir;
  assign fill_idx  = r_idx;
  assign lbp_addr  = {r_row, r_col};
  assign lbp_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_lbp_window_agu.sv
// Directed bench for lbp_window_agu: 8x8 and 8x3 images, WIN=3, ADDR_W=3; follows LBP_AGU_SNAKE_EN.
module tb_lbp_window_agu;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, start1 = 1'b0;
  logic gray_ready = 1'b1, proc_ready = 1'b1;
  logic gray_req, lbp_valid, busy, done;
  logic [5:0] gray_addr, lbp_addr, fill_idx;
  logic [1:0] fill_dir;
  logic gray_req_1, lbp_valid_1, busy_1, done_1;
  logic [5:0] gray_addr_1, lbp_addr_1, fill_idx_1;
  logic [1:0] fill_dir_1;

  always #5 clk = ~clk;

  lbp_window_agu #(.ADDR_W(3), .IMG_W(8), .IMG_H(8), .WIN(3)) u0 (
    .clk(clk), .reset(reset), .start(start), .gray_req(gray_req), .gray_ready(gray_ready),
    .gray_addr(gray_addr), .fill_dir(fill_dir), .fill_idx(fill_idx), .lbp_addr(lbp_addr),
    .lbp_valid(lbp_valid), .proc_ready(proc_ready), .busy(busy), .done(done));

  lbp_window_agu #(.ADDR_W(3), .IMG_W(8), .IMG_H(3), .WIN(3)) u1 (
    .clk(clk), .reset(reset), .start(start1), .gray_req(gray_req_1), .gray_ready(gray_ready),
    .gray_addr(gray_addr_1), .fill_dir(fill_dir_1), .fill_idx(fill_idx_1), .lbp_addr(lbp_addr_1),
    .lbp_valid(lbp_valid_1), .proc_ready(proc_ready), .busy(busy_1), .done(done_1));

  int passed = 0, total = 0, nfail = 0;
  logic [5:0] gq[$], lq[$], sgq[$], slq[$];
  logic [1:0] dq[$];
  int ndone = 0, nbusydone = 0, ndir23 = 0, nunst = 0;
  int nwin1 = 0, ndone1 = 0, ndown1 = 0;
  logic [5:0] last1 = '0;
  logic g_stall = 1'b0, l_stall = 1'b0;
  logic [5:0] g_hold = '0, l_hold = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // handshakes seen at negedge are the ones the next rising edge will accept
  always @(negedge clk) begin
    if (reset) begin
      g_stall = 1'b0;
      l_stall = 1'b0;
    end else begin
      if (gray_req && gray_ready) begin gq.push_back(gray_addr); dq.push_back(fill_dir); end
      if (lbp_valid && proc_ready) lq.push_back(lbp_addr);
      if (done) ndone++;
      if (done && busy) nbusydone++;
      if (gray_req && fill_dir[1]) ndir23++;
      if (g_stall && (gray_req !== 1'b1 || gray_addr !== g_hold)) nunst++;
      if (l_stall && (lbp_valid !== 1'b1 || lbp_addr !== l_hold)) nunst++;
      g_stall = gray_req && !gray_ready;
      g_hold  = gray_addr;
      l_stall = lbp_valid && !proc_ready;
      l_hold  = lbp_addr;
      if (lbp_valid_1 && proc_ready) begin nwin1++; last1 = lbp_addr_1; end
      if (gray_req_1 && fill_dir_1 == 2'd2) ndown1++;
      if (done_1) ndone1++;
    end
  end

  initial begin
    int cyc, nmis;
    logic [5:0] ei[9];
    logic [5:0] er[9];
    ei = '{6'd0, 6'd1, 6'd2, 6'd8, 6'd9, 6'd10, 6'd16, 6'd17, 6'd18};
    er = '{6'd8, 6'd9, 6'd10, 6'd16, 6'd17, 6'd18, 6'd24, 6'd25, 6'd26};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_gray_req", gray_req, 0);
    chk("rst_gray_addr", gray_addr, 0);
    chk("rst_lbp_valid", lbp_valid, 0);
    chk("rst_lbp_addr", lbp_addr, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_dir_idx", {fill_dir, fill_idx}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // run 1: both readies high, extra start pulse while busy
    start = 1'b1;
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk("first_req", gray_req, 1);
        chk("first_addr", gray_addr, 0);
        chk("busy_on", busy, 1);
      end
      if (cyc == 10) begin
        chk("first_valid", lbp_valid, 1);
        chk("first_lbp", lbp_addr, 9);
      end
      if (cyc == 20) start = 1'b1;
      if (cyc == 21) start = 1'b0;
      if (done) break;
    end
`ifdef LBP_AGU_SNAKE_EN
    chk("done_cycle", cyc, 151);
    chk("fetch_count", gq.size(), 114);
`else
    chk("done_cycle", cyc, 181);
    chk("fetch_count", gq.size(), 144);
`endif
    chk("busy_with_done", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", ndone, 1);
    chk("busy_at_done", nbusydone, 0);
    chk("windows", lq.size(), 36);
    nmis = 0;
    for (int i = 0; i < 9; i++) if (gq[i] !== ei[i] || dq[i] !== 2'd0) nmis++;
    chk("init_fill", nmis, 0);
    chk("lbp0", lq[0], 9);
    chk("right_a", gq[9], 3);
    chk("right_b", gq[10], 11);
    chk("right_c", gq[11], 19);
    chk("right_dir", dq[9], 1);
    chk("lbp1", lq[1], 10);
    chk("lbp_row_end", lq[5], 14);
`ifdef LBP_AGU_SNAKE_EN
    chk("down_a", gq[24], 29);
    chk("down_b", gq[25], 30);
    chk("down_c", gq[26], 31);
    chk("down_dir", dq[24], 2);
    chk("lbp_down", lq[6], 22);
    chk("left_a", gq[27], 12);
    chk("left_b", gq[28], 20);
    chk("left_c", gq[29], 28);
    chk("left_dir", dq[27], 3);
    chk("lbp_left", lq[7], 21);
`else
    nmis = 0;
    for (int i = 0; i < 9; i++) if (gq[24+i] !== er[i] || dq[24+i] !== 2'd0) nmis++;
    chk("row2_init", nmis, 0);
    chk("lbp_row2", lq[6], 17);
    chk("no_dir23", ndir23, 0);
`endif
    sgq = gq;
    slq = lq;

    // run 2: random stalls on both handshakes
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    gq.delete(); dq.delete(); lq.delete();
    nunst = 0;
    start = 1'b1;
    cyc = 0;
    while (cyc < 6000) begin
      gray_ready = 1'($urandom_range(0, 1));
      proc_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (done) break;
    end
    chk("stall_done", done, 1);
    gray_ready = 1'b1;
    proc_ready = 1'b1;
    @(negedge clk); #1;
    chk("stall_stable", nunst, 0);
    chk("stall_fetch_len", gq.size(), sgq.size());
    chk("stall_win_len", lq.size(), slq.size());
    nmis = 0;
    foreach (sgq[i]) if (i < gq.size() && gq[i] !== sgq[i]) nmis++;
    foreach (slq[i]) if (i < lq.size() && lq[i] !== slq[i]) nmis++;
    chk("stall_sequence", nmis, 0);

    // run 3: reset in the middle of the first right fill
    @(posedge clk); #1;
    gq.delete(); dq.delete(); lq.delete();
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pre_reset_dir", fill_dir, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_req_valid", {gray_req, lbp_valid, busy, done}, 0);
    chk("mid_rst_addrs", {gray_addr, lbp_addr}, 0);
    chk("mid_rst_dir_idx", {fill_dir, fill_idx}, 0);
    reset = 1'b0;
    gq.delete(); dq.delete(); lq.delete();
    start = 1'b1;
    cyc = 0;
    while (cyc < 100 && lq.size() < 1) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk("restart_window", lq.size(), 1);
    nmis = 0;
    for (int i = 0; i < 9; i++) if (gq[i] !== ei[i]) nmis++;
    chk("restart_init", nmis, 0);
    chk("restart_lbp0", lq[0], 9);
    cyc = 0;
    while (cyc < 2000 && !done) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("restart_done", done, 1);

    // run 4: 8x3 image, single row
    @(posedge clk); #1;
    start1 = 1'b1;
    cyc = 0;
    while (cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
      start1 = 1'b0;
      if (done_1) break;
    end
    chk("h3_done_cycle", cyc, 31);
    repeat (2) @(posedge clk);
    #1;
    chk("h3_windows", nwin1, 6);
    chk("h3_no_down", ndown1, 0);
    chk("h3_last_lbp", last1, 14);
    chk("h3_done_pulses", ndone1, 1);
    chk("h3_busy", busy_1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lbp_window_agu.md
# lbp_window_agu

Parametrised window address generator for the LBP datapath, successor to the fixed 128x128 / 3x3 gray-address controller. It owns the complete window scan: it sequences the centre pixel over the image, issues gray-memory fetch addresses for each window fill (full initial fill or incremental edge fill) under a request/ready handshake, and presents each completed window's centre address to the LBP compute stage under a valid/ready handshake. Image size and window size are parameters. The scan order (serpentine or raster) is compile-time selectable.

## Interface
- ADDR_W, 7, bits per row/col coordinate; addresses pack as {row, col}, 2*ADDR_W bits
- IMG_W, 128, image width in pixels, WIN <= IMG_W <= 2^ADDR_W
- IMG_H, 128, image height in pixels, WIN <= IMG_H <= 2^ADDR_W
- WIN, 3, window side, odd, 3..7; R = (WIN-1)/2

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a frame scan; sampled only in IDLE
- gray_req  out  1  fetch request valid
- gray_ready  in  1  gray memory accepts current gray_addr
- gray_addr  out  2*ADDR_W  pixel address of current fetch
- fill_dir  out  2  fill type of current fetch: 0 init, 1 right, 2 down, 3 left
- fill_idx  out  6  index of current fetch within its fill (0..WIN*WIN-1 for init, 0..WIN-1 otherwise)
- lbp_addr  out  2*ADDR_W  centre address of current window
- lbp_valid  out  1  window complete, lbp_addr valid
- proc_ready  in  1  LBP stage consumes the window
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last window is consumed

## Operation
- FSM: IDLE -> FETCH -> WAIT -> (FETCH | FINISH) -> IDLE.
- IDLE: on start=1, centre := (R,R). fill_dir := 0. busy := 1. Go to FETCH.
- FETCH: gray_req=1. gray_addr is held stable until gray_req && gray_ready. Each accepted fetch advances fill_idx. The last accepted fetch of a fill goes to WAIT.
  - Init order is row-major: row r-R+fill_idx/WIN, col c-R+fill_idx%WIN.
  - Right fetches col c+R+1, rows r-R..r+R ascending.
  - Left fetches col c-R-1, rows r-R..r+R ascending.
  - Down fetches row r+R+1, cols c-R..c+R ascending.
- Centre moves to the new position when the fill starts. lbp_addr always reflects the window being filled or held.
- WAIT: lbp_valid=1 and lbp_addr held until proc_ready. On consumption:
  - Last window: go to FINISH.
  - Otherwise: select the next fill per scan order and go to FETCH.
- Serpentine scan (macro defined): right along the row to col IMG_W-1-R, then down, then left to col R, then down, and so on. The last centre row is IMG_H-1-R.
- FINISH: done=1 for one cycle, busy := 0, then IDLE.
- Arithmetic is ADDR_W-bit unsigned. Coordinates never leave [0, IMG-1] by construction.
- Window count is (IMG_W-2R)*(IMG_H-2R).
- Boundary rules:
  - start while busy: ignored.
  - proc_ready with lbp_valid=0: ignored.
  - gray_ready with gray_req=0: ignored.
  - IMG_W == WIN: only down fills, never right/left.
  - IMG_H == WIN: single row, no down fill.
  - reset in any state: next cycle IDLE with all outputs at reset values, no partial fill kept.
- Reset values: gray_req 0, gray_addr 0, fill_dir 0, fill_idx 0, lbp_addr 0, lbp_valid 0, busy 0, done 0.

## Timing
- start accepted at edge N -> gray_req=1 from cycle N+1.
- With gray_ready held 1, one fetch per cycle. The fetch accepted at edge M (last of fill) gives lbp_valid=1 from cycle M+1.
- proc_ready accepted at edge P gives the next gray_req=1 in cycle P+1 (zero-bubble turnaround), or done=1 in cycle P+1.
- Steady state with both ready tied high: WIN+1 cycles per window, WIN*WIN+1 for init.
- gray_addr, fill_dir, fill_idx, lbp_addr and all control outputs are registered; no combinational input-to-output paths.

## Configuration
- LBP_AGU_SNAKE_EN defined: serpentine scan as above. Only the first window uses an init fill.
- Not defined: raster scan. Every row starts with a fresh init fill at (r,R); right fills within the row. No left or down fills are emitted; fill_dir is never 2 or 3.

## Test plan
- ADDR_W=3, 8x8, WIN=3, snake, both readies tied 1, start pulse -> gray_addr 0,1,2,8,9,10,16,17,18 with fill_dir 0, then lbp_valid with lbp_addr 9; next fill 3,11,19 (dir 1) with lbp_addr 10.
- Same config, continue to row end -> lbp_addr 14, then down fill 29,30,31 (dir 2) lbp_addr 22, then left fill 12,20,28 (dir 3) lbp_addr 21; 36 windows total, done pulses once, busy falls with it.
- Same config without LBP_AGU_SNAKE_EN -> after lbp_addr 14, init fill 8,9,10,16,17,18,24,25,26 and lbp_addr 17; fill_dir never 2 or 3.
- Random gray_ready/proc_ready stalls (50%) -> gray_addr/lbp_addr stable while stalled; accepted address sequence identical to the no-stall run.
- reset asserted mid-way through a right fill, then start -> outputs at reset values the cycle after reset; the new scan repeats the first-window sequence from gray_addr 0.
- start pulsed during busy, and an 8x3 image (IMG_H=WIN) -> the extra start is ignored; the 8x3 image yields 6 windows with no down fill.
